// File: rtl/ps2_keypad_controller.sv
// -----------------------------------------------------------------------------
// ps2_keypad_controller
//
// Brings the PS2Clk-domain scancode/keyPressed pair into the system clock
// domain, waits until it has settled, and turns each new key press into one
// decoded key event. Typematic repeats and key releases produce no event.
// Events are queued in a small FIFO with a valid/ready handshake.
//
// Ports
//   clk              in   system clock, all state on the rising edge
//   rstn             in   asynchronous active-low reset
//   ps2_scancode     in   [7:0] scancode from the PS/2 receiver (PS2Clk domain)
//   ps2_key_pressed  in   keyPressed from the PS/2 receiver (PS2Clk domain)
//   key_ready        in   consumer accepts the head event this cycle
//   clear_ovf        in   clears the sticky overflow flag
//   key_valid        out  FIFO not empty, head event presented
//   key_code         out  [3:0] decoded head event (0-9, 10 Enter, 11 Bksp,
//                         12 Esc, 15 other)
//   key_raw          out  [7:0] raw scancode of the head event
//   fifo_count       out  [clog2(DEPTH):0] number of queued events
//   overflow         out  sticky: an event was dropped on a full FIFO
// -----------------------------------------------------------------------------
module ps2_keypad_controller #(
    parameter int SETTLE_CYCLES = 4,   // 1..255
    parameter int DEPTH         = 4,   // power of 2, 2..16
    parameter int PASS_UNKNOWN  = 0    // 1: queue unmapped codes as 15
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [7:0]               ps2_scancode,
    input  logic                     ps2_key_pressed,
    input  logic                     key_ready,
    input  logic                     clear_ovf,
    output logic                     key_valid,
    output logic [3:0]               key_code,
    output logic [7:0]               key_raw,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    SETTLE_U8 = 8'(SETTLE_CYCLES);
    localparam logic [CW-1:0] DEPTH_CW  = CW'(DEPTH);

    typedef enum logic {ST_IDLE, ST_HELD} state_t;

    // ------------------------------------------------------------------
    // Synchronizer and settle counter
    // ------------------------------------------------------------------
    logic [8:0] r_sync1, r_sync2;
    logic [7:0] r_settle_cnt;
    logic       w_stable;
    logic       w_pressed;
    logic [7:0] w_scancode;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_sync1 <= {ps2_key_pressed, ps2_scancode};
            r_sync2 <= r_sync1;
            // The counter restarts on the same edge that stage 2 takes a new
            // value, so it counts how long stage 2 has held its current value.
            if (r_sync1 != r_sync2)
                r_settle_cnt <= '0;
            else if (r_settle_cnt != SETTLE_U8)
                r_settle_cnt <= r_settle_cnt + 8'd1;
        end
    end

    assign w_stable   = (r_settle_cnt == SETTLE_U8);
    assign w_pressed  = r_sync2[8];
    assign w_scancode = r_sync2[7:0];

    // ------------------------------------------------------------------
    // Scancode decode
    // ------------------------------------------------------------------
    function automatic logic [3:0] decode(input logic [7:0] sc);
        case (sc)
            8'h45, 8'h70: decode = 4'd0;
            8'h16, 8'h69: decode = 4'd1;
            8'h1E, 8'h72: decode = 4'd2;
            8'h26, 8'h7A: decode = 4'd3;
            8'h25, 8'h6B: decode = 4'd4;
            8'h2E, 8'h73: decode = 4'd5;
            8'h36, 8'h74: decode = 4'd6;
            8'h3D, 8'h6C: decode = 4'd7;
            8'h3E, 8'h75: decode = 4'd8;
            8'h46, 8'h7D: decode = 4'd9;
            8'h5A:        decode = 4'd10;
            8'h66:        decode = 4'd11;
            8'h76:        decode = 4'd12;
            default:      decode = 4'd15;
        endcase
    endfunction

    logic [3:0] w_code;
    assign w_code = decode(w_scancode);

    // ------------------------------------------------------------------
    // Press-tracking FSM
    // ------------------------------------------------------------------
    state_t     r_state, w_state_next;
    logic [7:0] r_last_code;
    logic       w_event;
    logic       w_push_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_last_code <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_event)
                r_last_code <= w_scancode;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_event      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_stable && w_pressed) begin
                    w_event      = 1'b1;
                    w_state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_stable) begin
                    if (!w_pressed)
                        w_state_next = ST_IDLE;
                    else if (w_scancode != r_last_code)
                        w_event = 1'b1;   // rollover onto a different key
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Unmapped keys still move the FSM but are only queued if enabled.
    assign w_push_req = w_event && ((w_code != 4'd15) || (PASS_UNKNOWN != 0));

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [11:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr, w_rd_next;
    logic [CW-1:0] r_count, w_count_next;
    logic [3:0]    r_key_code;
    logic [7:0]    r_key_raw;
    logic          r_overflow;
    logic          w_pop, w_full, w_push;
    logic [11:0]   w_wdata, w_head_next;

    assign w_wdata   = {w_code, w_scancode};
    assign w_pop     = (r_count != '0) && key_ready;
    assign w_full    = (r_count == DEPTH_CW);
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_rd_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_count_next = r_count - CW'(1);
    end

    // The next head is the entry being written this cycle when it lands in
    // the slot the read pointer is about to point at; otherwise storage.
    assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? w_wdata
                                                               : r_mem[w_rd_next];

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and key_code/key_raw come from reset registers.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_key_code <= '0;
            r_key_raw  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            // Outputs hold the last head when the FIFO drains empty.
            if (w_count_next != '0)
                {r_key_code, r_key_raw} <= w_head_next;
            // Setting wins over clearing in the same cycle.
            if (w_push_req && w_full && !w_pop)
                r_overflow <= 1'b1;
            else if (clear_ovf)
                r_overflow <= 1'b0;
        end
    end

    assign key_valid  = (r_count != '0);
    assign key_code   = r_key_code;
    assign key_raw    = r_key_raw;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
